// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                  |
// | Description : Hazard and forwarding controller for the in-order pipeline. |
// |               Shadows the EX/MEM/WB destinations and produces the decode  |
// |               forwarding selects, fetch/decode stalls, the EX bubble and  |
// |               the multi-cycle mul/div occupancy.                          |
// | Config      : HAZARD_ALU_FWD_EN - when defined, an EX-stage non-load      |
// |               producer is forwarded from ALU_out (2'b10); otherwise it    |
// |               stalls until the result reaches WB.                         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int MULDIV_LAT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] id_dst,
   input  logic       id_wen,
   input  logic       id_is_load,
   input  logic       id_is_muldiv,
   input  logic       dmem_busy,
   input  logic       flush,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b,
   output logic       stall_f,
   output logic       stall_d,
   output logic       bubble_e,
   output logic       muldiv_busy
);

   localparam logic [5:0] C_MD_LOAD = 6'(MULDIV_LAT - 1);

   // Only the EX slot needs the load flag: MEM always stalls and WB always
   // forwards, whatever the producer kind.
   typedef struct packed {
      logic       v;
      logic [4:0] dst;
      logic       wen;
   } slot_t;

   slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic       ex_ld_q, ex_ld_d;
   logic [5:0] md_cnt_q, md_cnt_d;
   logic       flush_pend_q, flush_pend_d;

   logic       w_freeze, w_flush_eff, w_issue, w_raw_any;
   logic [2:0] w_res_a, w_res_b;

   function automatic logic slot_match(input slot_t s, input logic [4:0] r,
                                       input logic use_r);
      return s.v & s.wen & (s.dst != 5'd0) & (s.dst == r) & use_r;
   endfunction

   // Result is {raw_stall, fwd[1:0]}; youngest slot wins.
   function automatic logic [2:0] resolve(input slot_t ex, input logic ex_ld,
                                          input slot_t mem, input slot_t wb,
                                          input logic [4:0] r, input logic use_r);
      logic [2:0] res;
      res = 3'b000;
      if (slot_match(ex, r, use_r)) begin
`ifdef HAZARD_ALU_FWD_EN
         res = ex_ld ? 3'b100 : 3'b010;
`else
         res = 3'b100;
         if (ex_ld) res = 3'b100;
`endif
      end else if (slot_match(mem, r, use_r)) begin
         res = 3'b100;
      end else if (slot_match(wb, r, use_r)) begin
         res = 3'b001;
      end
      return res;
   endfunction

   // Hazard resolution, pipeline controls and next-state of all registers.
   always_comb begin
      w_res_a      = resolve(ex_q, ex_ld_q, mem_q, wb_q, id_rs1, id_use_rs1);
      w_res_b      = resolve(ex_q, ex_ld_q, mem_q, wb_q, id_rs2, id_use_rs2);
      muldiv_busy  = (md_cnt_q != 6'd0);
      w_freeze     = dmem_busy | muldiv_busy;
      w_flush_eff  = (flush | flush_pend_q) & ~w_freeze;
      w_raw_any    = id_valid & (w_res_a[2] | w_res_b[2]);
      // A killed instruction cannot cause a stall.
      stall_d      = w_freeze | (w_raw_any & ~w_flush_eff);
      stall_f      = stall_d;
      w_issue      = id_valid & ~stall_d & ~w_flush_eff;
      bubble_e     = ~w_freeze & ~w_issue;
      forward_a    = w_res_a[1:0];
      forward_b    = w_res_b[1:0];

      ex_d         = ex_q;
      ex_ld_d      = ex_ld_q;
      mem_d        = mem_q;
      wb_d         = wb_q;
      if (!w_freeze) begin
         wb_d    = mem_q;
         mem_d   = ex_q;
         ex_d    = '{v: w_issue, dst: id_dst, wen: id_wen};
         ex_ld_d = w_issue & id_is_load;
      end

      // Counter keeps running through dmem_busy so mul/div latency is fixed.
      md_cnt_d = md_cnt_q;
      if (w_issue && id_is_muldiv)  md_cnt_d = C_MD_LOAD;
      else if (md_cnt_q != 6'd0)    md_cnt_d = md_cnt_q - 6'd1;

      flush_pend_d = w_freeze ? (flush_pend_q | flush) : 1'b0;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q         <= '0;
         ex_ld_q      <= 1'b0;
         mem_q        <= '0;
         wb_q         <= '0;
         md_cnt_q     <= 6'd0;
         flush_pend_q <= 1'b0;
      end else begin
         ex_q         <= ex_d;
         ex_ld_q      <= ex_ld_d;
         mem_q        <= mem_d;
         wb_q         <= wb_d;
         md_cnt_q     <= md_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                               |
// | Description : Self-checking bench for hazard_ctrl with a queue-based      |
// |               in-flight instruction model.                                |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

   localparam int LAT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_dst = '0;
   logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wen = 1'b0;
   logic       id_is_load = 1'b0, id_is_muldiv = 1'b0;
   logic       dmem_busy = 1'b0, flush = 1'b0;
   logic [1:0] forward_a, forward_b;
   logic       stall_f, stall_d, bubble_e, muldiv_busy;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load),
      .id_is_muldiv(id_is_muldiv), .dmem_busy(dmem_busy), .flush(flush),
      .forward_a(forward_a), .forward_b(forward_b), .stall_f(stall_f),
      .stall_d(stall_d), .bubble_e(bubble_e), .muldiv_busy(muldiv_busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // In-flight instructions with their age since issue (0=EX, 1=MEM, 2=WB).
   typedef struct {
      logic [4:0] dst;
      bit         wen;
      bit         ld;
      int         age;
   } ent_t;

   ent_t inflight[$];
   int   m_md_left = 0;
   bit   m_fpend = 0;
   bit   m_freeze, m_fl, m_stall, m_issue, m_bubble, m_raw_a, m_raw_b;
   logic [1:0] m_fwd_a, m_fwd_b;

   task automatic model_reset();
      inflight.delete();
      m_md_left = 0;
      m_fpend   = 0;
   endtask

   task automatic find(input logic [4:0] r, input bit use_r, output int age, output bit ld);
      age = -1;
      ld  = 0;
      foreach (inflight[i]) begin
         if (use_r && inflight[i].wen && inflight[i].dst != 0 && inflight[i].dst == r &&
             (age < 0 || inflight[i].age < age)) begin
            age = inflight[i].age;
            ld  = inflight[i].ld;
         end
      end
   endtask

   task automatic decide(input int age, input bit ld, output bit raw, output logic [1:0] fwd);
      raw = 0;
      fwd = 2'b00;
      if (age == 0) begin
`ifdef HAZARD_ALU_FWD_EN
         if (ld) raw = 1; else fwd = 2'b10;
`else
         raw = 1;
`endif
      end else if (age == 1) raw = 1;
      else if (age == 2) fwd = 2'b01;
   endtask

   task automatic model_eval();
      int aa, ab;
      bit la, lb;
      m_freeze = dmem_busy || (m_md_left > 0);
      find(id_rs1, id_use_rs1, aa, la);
      find(id_rs2, id_use_rs2, ab, lb);
      decide(aa, la, m_raw_a, m_fwd_a);
      decide(ab, lb, m_raw_b, m_fwd_b);
      m_fl     = (flush || m_fpend) && !m_freeze;
      m_stall  = m_freeze || (id_valid && (m_raw_a || m_raw_b) && !m_fl);
      m_issue  = id_valid && !m_stall && !m_fl;
      m_bubble = !m_freeze && !m_issue;
   endtask

   task automatic model_advance();
      ent_t nq[$];
      ent_t e;
      if (!m_freeze) begin
         foreach (inflight[i]) begin
            if (inflight[i].age < 2) begin
               e = inflight[i];
               e.age++;
               nq.push_back(e);
            end
         end
         if (m_issue) begin
            e.dst = id_dst; e.wen = id_wen; e.ld = id_is_load; e.age = 0;
            nq.push_back(e);
         end
         inflight = nq;
      end
      if (m_md_left > 0) m_md_left--;
      if (m_issue && id_is_muldiv) m_md_left = LAT - 1;
      m_fpend = m_freeze ? (m_fpend || flush) : 0;
   endtask

   // One clock: model sees the pre-edge inputs, DUT clocks, settle 1ns.
   task automatic tick();
      model_eval();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int dst, input bit wen, input bit ld, input bit md);
      id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
      id_dst = 5'(dst); id_wen = wen; id_is_load = ld; id_is_muldiv = md;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_busy = 0;
      flush = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1;
      model_reset();
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
      #2;
      total++; if (forward_a !== 2'b00 || forward_b !== 2'b00) begin bad++;
         $display("FAIL reset_fwd got=%b/%b exp=00/00", forward_a, forward_b); end
      total++; if (stall_d !== 1'b0 || stall_f !== 1'b0) begin bad++;
         $display("FAIL reset_stall got=%b/%b exp=0/0", stall_d, stall_f); end
      total++; if (bubble_e !== 1'b0 || muldiv_busy !== 1'b0) begin bad++;
         $display("FAIL reset_bubble_busy got=%b/%b exp=0/0", bubble_e, muldiv_busy); end
      id_valid = 0;
      #1;
      total++; if (bubble_e !== 1'b1) begin bad++;
         $display("FAIL reset_bubble_novalid got=%b exp=1", bubble_e); end
      @(negedge clk);
      reset = 0;
      idle(2);
   endtask

   task automatic test_alu_fwd();
      drive(1, 1, 2, 1, 1, 5, 1, 0, 0);          // addi x5
      tick();
      drive(1, 5, 0, 1, 0, 8, 1, 0, 0);          // consumer of x5
      #1;
`ifdef HAZARD_ALU_FWD_EN
      total++; if (forward_a !== 2'b10 || stall_d !== 1'b0) begin bad++;
         $display("FAIL alu_fwd got=%b stall=%b exp=10 stall=0", forward_a, stall_d); end
`else
      for (int k = 0; k < 2; k++) begin
         total++; if (stall_d !== 1'b1 || bubble_e !== 1'b1) begin bad++;
            $display("FAIL alu_nofwd_stall%0d got=%b/%b exp=1/1", k, stall_d, bubble_e); end
         tick();
         #1;
      end
      total++; if (forward_a !== 2'b01 || stall_d !== 1'b0) begin bad++;
         $display("FAIL alu_nofwd_wb got=%b stall=%b exp=01 stall=0", forward_a, stall_d); end
`endif
      tick();
      idle(4);
   endtask

   task automatic test_load_use();
      drive(1, 1, 1, 1, 0, 6, 1, 1, 0);          // ld x6
      tick();
      drive(1, 6, 6, 1, 1, 7, 1, 0, 0);          // add x7,x6,x6
      #1;
      for (int k = 0; k < 2; k++) begin
         total++; if (stall_d !== 1'b1 || stall_f !== 1'b1 || bubble_e !== 1'b1) begin bad++;
            $display("FAIL load_use_stall%0d got=%b%b%b exp=111", k, stall_d, stall_f, bubble_e); end
         tick();
         #1;
      end
      total++; if (forward_a !== 2'b01 || forward_b !== 2'b01 || stall_d !== 1'b0) begin bad++;
         $display("FAIL load_use_issue got=%b/%b stall=%b exp=01/01 stall=0",
                  forward_a, forward_b, stall_d); end
      tick();
      idle(4);
   endtask

   task automatic test_muldiv();
      drive(1, 1, 2, 1, 1, 9, 1, 0, 1);          // mul x9
      #1;
      total++; if (stall_d !== 1'b0 || muldiv_busy !== 1'b0) begin bad++;
         $display("FAIL md_issue got=%b/%b exp=0/0", stall_d, muldiv_busy); end
      tick();
      drive(1, 9, 0, 1, 0, 10, 1, 0, 0);         // dependent on x9
      for (int k = 1; k < LAT; k++) begin
         #1;
         total++; if (muldiv_busy !== 1'b1 || stall_d !== 1'b1) begin bad++;
            $display("FAIL md_busy t+%0d got=%b/%b exp=1/1", k, muldiv_busy, stall_d); end
         tick();
      end
      #1;
      total++; if (muldiv_busy !== 1'b0) begin bad++;
         $display("FAIL md_done got=%b exp=0", muldiv_busy); end
`ifdef HAZARD_ALU_FWD_EN
      total++; if (forward_a !== 2'b10 || stall_d !== 1'b0) begin bad++;
         $display("FAIL md_dep_fwd got=%b stall=%b exp=10 stall=0", forward_a, stall_d); end
`else
      total++; if (stall_d !== 1'b1) begin bad++;
         $display("FAIL md_dep_nofwd stall got=%b exp=1", stall_d); end
`endif
      tick();
      idle(12);
   endtask

   task automatic test_flush_freeze();
      dmem_busy = 1;
      drive(1, 1, 2, 1, 1, 10, 1, 0, 0);
      #1;
      total++; if (stall_d !== 1'b1 || bubble_e !== 1'b0) begin bad++;
         $display("FAIL ff_frozen got=%b/%b exp=1/0", stall_d, bubble_e); end
      flush = 1;
      tick();
      flush = 0;
      #1;
      total++; if (stall_d !== 1'b1) begin bad++;
         $display("FAIL ff_still_frozen got=%b exp=1", stall_d); end
      tick();
      dmem_busy = 0;
      #1;
      total++; if (bubble_e !== 1'b1 || stall_d !== 1'b0) begin bad++;
         $display("FAIL ff_apply got=%b/%b exp=1/0", bubble_e, stall_d); end
      tick();
      drive(1, 10, 0, 1, 0, 12, 1, 0, 0);        // would hit x10 if it were recorded
      #1;
      total++; if (forward_a !== 2'b00 || stall_d !== 1'b0) begin bad++;
         $display("FAIL ff_killed got=%b stall=%b exp=00 stall=0", forward_a, stall_d); end
      tick();
      idle(4);
   endtask

   task automatic test_x0();
      drive(1, 1, 2, 1, 1, 0, 1, 0, 0);          // producer rd = x0
      tick();
      drive(1, 0, 0, 1, 1, 3, 1, 0, 0);
      #1;
      total++; if (forward_a !== 2'b00 || forward_b !== 2'b00 || stall_d !== 1'b0) begin bad++;
         $display("FAIL x0 got=%b/%b stall=%b exp=00/00 stall=0", forward_a, forward_b, stall_d); end
      tick();
      idle(4);
   endtask

   task automatic test_reset_muldiv();
      drive(1, 1, 2, 1, 1, 11, 1, 0, 1);         // div x11
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      #1;
      total++; if (muldiv_busy !== 1'b1) begin bad++;
         $display("FAIL rmd_before got=%b exp=1", muldiv_busy); end
      reset = 1;
      model_reset();
      #1;
      total++; if (muldiv_busy !== 1'b0) begin bad++;
         $display("FAIL rmd_abort got=%b exp=0", muldiv_busy); end
      drive(1, 11, 11, 1, 1, 4, 1, 0, 0);
      #1;
      reset = 0;
      #1;
      total++; if (forward_a !== 2'b00 || forward_b !== 2'b00 || stall_d !== 1'b0) begin bad++;
         $display("FAIL rmd_empty got=%b/%b stall=%b exp=00/00 stall=0",
                  forward_a, forward_b, stall_d); end
      tick();
      idle(4);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom % 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom % 2, $urandom % 2, $urandom_range(0, 3), ($urandom % 4) != 0,
               ($urandom % 4) == 0, ($urandom % 12) == 0);
         dmem_busy = ($urandom % 6) == 0;
         flush     = ($urandom % 8) == 0;
         #1;
         model_eval();
         total++; if (stall_d !== m_stall || stall_f !== m_stall) begin bad++;
            $display("FAIL rnd_stall c=%0d got=%b/%b exp=%b", c, stall_d, stall_f, m_stall); end
         total++; if (bubble_e !== m_bubble) begin bad++;
            $display("FAIL rnd_bubble c=%0d got=%b exp=%b", c, bubble_e, m_bubble); end
         total++; if (muldiv_busy !== (m_md_left > 0)) begin bad++;
            $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, muldiv_busy, m_md_left > 0); end
         if (!m_raw_a) begin
            total++; if (forward_a !== m_fwd_a) begin bad++;
               $display("FAIL rnd_fwd_a c=%0d got=%b exp=%b", c, forward_a, m_fwd_a); end
         end
         if (!m_raw_b) begin
            total++; if (forward_b !== m_fwd_b) begin bad++;
               $display("FAIL rnd_fwd_b c=%0d got=%b exp=%b", c, forward_b, m_fwd_b); end
         end
         tick();
      end
      idle(12);
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_muldiv();
      test_flush_freeze();
      test_x0();
      test_reset_muldiv();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the in-order pipeline. It keeps a shadow scoreboard of the instructions in EX, MEM and WB, and uses it to drive the decode-stage operand forwarding selects (`forwardingAA`/`forwardingBB` encoding). It also produces the fetch/decode stall and EX-bubble controls and sequences multi-cycle mul/div occupancy. It sits beside `decode`, and its outputs feed the decode forwarding muxes and the pipeline register enables.

## Interface
Parameters:
- `MULDIV_LAT`, default 8: EX-stage occupancy of a mul/div op in cycles; legal range 2..64.

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_rs1`, `id_rs2`  in  5 each  source register indices (raw_instr[19:15], [24:20])
- `id_use_rs1`, `id_use_rs2`  in  1 each  source is actually read
- `id_dst`  in  5  destination index (raw_instr[11:7])
- `id_wen`  in  1  instruction writes rd
- `id_is_load`  in  1  instruction is a load
- `id_is_muldiv`  in  1  instruction is mul/div
- `dmem_busy`  in  1  MEM stage waiting on memory; freezes the whole pipeline
- `flush`  in  1  branch redirect from EX; kills the instruction in ID
- `forward_a`, `forward_b`  out  2 each  forwarding select: 2'b00 regfile, 2'b01 WB, 2'b10 ALU_out
- `stall_f`, `stall_d`  out  1 each  hold the PC and the F/D register
- `bubble_e`  out  1  load a bubble into the D/E register
- `muldiv_busy`  out  1  mul/div occupying EX

## Operation
- **Scoreboard slots.** There are three slots, EX, MEM and WB. Each holds {valid, dst, wen, is_load}.
- **Slot match.** `match(S,r)` = S.valid & S.wen & (S.dst != 0) & (S.dst == r) & use_r.
- **Per-operand resolution.** Check slots youngest first and stop at the first match:
  - EX match, not a load: fwd = 2'b10.
  - EX match, load: raw stall.
  - MEM match: raw stall. Decode has no MEM forward path.
  - WB match: fwd = 2'b01.
  - No match: 2'b00.
- **freeze** = `dmem_busy` | `muldiv_busy`.
- **stall_d** = `stall_f` = freeze | (`id_valid` & raw stall on either operand).
- **Issue.** issue = `id_valid` & !stall_d & !flush_eff.
- **flush_eff.** flush_eff = (`flush` | flush_pend) & !freeze.
- **bubble_e** = !freeze & !issue.
- **Slot advance** (only when !freeze): WB<=MEM, MEM<=EX, EX<= issue ? {1,id_dst,id_wen,id_is_load} : invalid.
- **Slot hold.** While frozen, all slots hold.
- **flush_pend.** Set by `flush` while freeze; cleared on the first non-frozen cycle, which is when it is applied.
- **Mul/div counter.** 6-bit down-counter. It loads MULDIV_LAT-1 when a muldiv issues and decrements while nonzero. `muldiv_busy` = (cnt != 0).
  - During busy, the muldiv stays in the EX slot.
  - `dmem_busy` during busy does not pause the counter.
- **Simultaneous events.**
  - freeze overrides raw stall and flush.
  - flush overrides issue.
  - raw stall with flush: the ID instruction is killed and no stall is asserted.

## Timing
- All outputs are combinational from registered state plus the ID inputs. State updates on posedge `clk`.
- **Reset** (async, immediate): all slots invalid, cnt = 0, flush_pend = 0. As a result the outputs are `forward_*` = 0, all stalls 0, `bubble_e` = 0 when `id_valid` = 1 (1 when `id_valid` = 0), and `muldiv_busy` = 0.
- **Load-use.** Costs exactly 2 stall cycles: the load passes EX, then MEM. The consumer issues with fwd = 01 when the load is in WB.
- **Mul/div.** Freezes the pipeline for MULDIV_LAT-1 cycles after issue. A dependent instruction then sees ALU forwarding (10) in the first unfrozen cycle.
- **Reset mid-mul/div.** Aborts the count. `muldiv_busy` drops the same cycle.

## Configuration
- **`HAZARD_ALU_FWD_EN` defined:** behaviour as above; EX non-load match gives 2'b10.
- **`HAZARD_ALU_FWD_EN` undefined:** an EX non-load match is a raw stall, and 2'b10 is never produced. The decode ALU_out input is unused in this build.

## Test plan
- **ALU forwarding:** `addi x5` issued, next ID reads rs1 = x5 -> `forward_a` = 10, no stall. With the macro off -> 2 stall cycles, then `forward_a` = 01.
- **Load-use:** `ld x6` followed by `add x7,x6,x6` -> `stall_d` high 2 cycles with `bubble_e` each, then `forward_a` = `forward_b` = 01 on issue.
- **Mul/div:** MULDIV_LAT = 8, `mul` issues at cycle t -> `muldiv_busy` and `stall_d` high t+1..t+7, low at t+8.
- **Flush under freeze:** `flush` pulsed while `dmem_busy` = 1 -> no issue until `dmem_busy` falls; the first unfrozen cycle gives `bubble_e` = 1 and the ID instruction is not recorded in EX.
- **x0:** rd = x0 producer followed by a consumer of x0 -> `forward_a` = 00, no stall.
- **Reset:** `reset` asserted at the 3rd busy cycle of a `div` -> `muldiv_busy` = 0 immediately; after release, the slots are empty and `forward_*` = 00.
